// File: rtl/sram_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg
// Shared types and constants for the 32-bit to 2x16-bit SRAM bridge.
//   state_e               : controller FSM states
//   SRAM_DATA_W/ADDR_W    : external SRAM geometry (256K x 16)
//   DEFAULT_BASE_ADDR     : byte address that maps to SRAM word 0
//   DEFAULT_ACCESS_CYCLES : clock cycles per 16-bit SRAM access
// ----------------------------------------------------------------------------
package sram_pkg;

    localparam int unsigned SRAM_DATA_W           = 16;
    localparam int unsigned SRAM_ADDR_W           = 18;
    localparam int unsigned WORD_IDX_W            = SRAM_ADDR_W - 1;
    localparam int unsigned DEFAULT_BASE_ADDR     = 1024;
    localparam int unsigned DEFAULT_ACCESS_CYCLES = 3;

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    // 32-bit word index inside the SRAM; bits above the SRAM size wrap.
    function automatic logic [WORD_IDX_W-1:0] word_index(input logic [31:0] addr,
                                                         input logic [31:0] base);
        return WORD_IDX_W'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// ----------------------------------------------------------------------------
// sram_controller
// Bridges one 32-bit read/write request from the memory stage onto the
// 16-bit off-chip SRAM as two accesses (low half, then high half).
//
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   wrEn, rdEn          : level requests, held until ready (write wins)
//   address             : byte address; address[1:0] ignored
//   writeData           : word to store
//   readData            : last word read (registered)
//   ready               : low while a request is pending and not completing
//   SRAM_DQ             : bidirectional SRAM data bus
//   SRAM_ADDR           : SRAM half-word address {word index, half}
//   SRAM_UB_N/LB_N/CE_N/OE_N : tied low
//   SRAM_WE_N           : active-low write strobe
//   addrErr             : only with SRAM_RANGE_CHECK_EN; high in DONE of a
//                         request whose address falls outside the SRAM window
//
// Build option: define SRAM_RANGE_CHECK_EN to reject out-of-window requests
// instead of wrapping them modulo the SRAM size.
// ----------------------------------------------------------------------------
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int unsigned ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wrEn,
    input  logic                   rdEn,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N
`ifdef SRAM_RANGE_CHECK_EN
    ,
    output logic                   addrErr
`endif
);

    localparam logic [31:0] BaseAddr    = 32'(BASE_ADDR);
    localparam logic [3:0]  LastCnt     = 4'(ACCESS_CYCLES - 1);
    localparam bit          SingleCycle = (ACCESS_CYCLES == 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [WORD_IDX_W-1:0] word_q, word_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;

    logic last_cycle;
    logic wr_phase;
    logic hi_phase;
    logic access_phase;
    logic req;

`ifdef SRAM_RANGE_CHECK_EN
    logic err_q, err_d;
    logic out_of_range;

    // Window is [BASE_ADDR, BASE_ADDR + 512 KB).
    assign out_of_range = (address < BaseAddr) ||
                          ((address - BaseAddr) >= 32'h0008_0000);
`endif

    assign req          = wrEn | rdEn;
    assign last_cycle   = (cnt_q == LastCnt);
    assign wr_phase     = (state_q == StWrLo) || (state_q == StWrHi);
    assign hi_phase     = (state_q == StRdHi) || (state_q == StWrHi);
    assign access_phase = (state_q != StIdle) && (state_q != StDone);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef SRAM_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef SRAM_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef SRAM_RANGE_CHECK_EN
        err_d   = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (req) begin
                    // Latch the request so SRAM pins stay stable for the whole access.
                    word_d  = word_index(address, BaseAddr);
                    wdata_d = writeData;
                    state_d = wrEn ? StWrLo : StRdLo;
`ifdef SRAM_RANGE_CHECK_EN
                    err_d = out_of_range;
                    if (out_of_range) begin
                        state_d = StDone;
                        if (!wrEn) begin
                            rdata_d = '0;
                        end
                    end
`endif
                end
            end
            StRdLo: begin
                if (last_cycle) begin
                    rdata_d[15:0] = SRAM_DQ;
                    state_d       = StRdHi;
                end
            end
            StRdHi: begin
                if (last_cycle) begin
                    rdata_d[31:16] = SRAM_DQ;
                    state_d        = StDone;
                end
            end
            StWrLo: begin
                if (last_cycle) begin
                    state_d = StWrHi;
                end
            end
            StWrHi: begin
                if (last_cycle) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Requests present here are ignored; they are resampled in IDLE.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Counter restarts on every state entry.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready    = ~req | (state_q == StDone);
    assign readData = rdata_q;

    assign SRAM_ADDR = access_phase ? {word_q, hi_phase} : '0;

    // WE_N rises for the last cycle of each half while DQ is still driven,
    // giving data hold past the strobe. A 1-cycle access keeps WE_N low.
    assign SRAM_WE_N = ~(wr_phase && (SingleCycle || !last_cycle));

    assign SRAM_DQ = wr_phase ? (hi_phase ? wdata_q[31:16] : wdata_q[15:0])
                              : {SRAM_DATA_W{1'bz}};

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

`ifdef SRAM_RANGE_CHECK_EN
    assign addrErr = (state_q == StDone) && err_q;
`endif

endmodule
